led_display_arbiter: RTL and testbench
======================================

// Module: led_display_arbiter
// PURPOSE
//  Shares the 4 front-panel LEDs between NREQ status requesters and the idle cylon pattern.
//  Each requester drives a 4-bit pattern and a request; highest priority wins.
//  A won pattern is held for a minimum visible dwell (pulse stretching) before re-arbitration.
//  When no requests are pending, the idle pattern (cylon1 q) is passed to the LEDs.
// PARAMETERS
//  NREQ   4   number of requesters; index 0 = highest priority
//  MXPRE  21  prescaler width; one dwell tick every 2**MXPRE clocks
//  DWELL  3   minimum display time in ticks; 0 is treated as 1
// PORTS
//  clock     in   1        system clock (40 MHz)
//  reset     in   1        asynchronous, active-high reset
//  req       in   NREQ     request per source, level-sensitive
//  pat       in   4*NREQ   pattern per source; source i in pat[4*i+3:4*i]
//  idle_pat  in   4        pattern shown when idle (cylon1 q)
//  q         out  4        registered LED drive
//  gnt       out  NREQ     one-hot registered grant; 0 when idle or in gap
//  busy      out  1        1 in SHOW or GAP
// BEHAVIOUR
//  Reset: q=0, gnt=0, busy=0, state=IDLE, prescaler=0, dwell=0, latched pattern=0.
//  Prescaler: free-running MXPRE-bit up-counter, wraps; tick = (prescaler == all ones), one clock wide.
//  Winner: lowest index i with req[i]=1, evaluated combinationally each cycle.
//  States:
//   IDLE: q<=idle_pat each cycle. If any req: gnt<=onehot(winner), latch pat of winner,
//         dwell<=max(DWELL,1), go to SHOW. Latency: req high at edge n -> gnt/q valid after edge n+1.
//   SHOW: q<=latched pattern (latched once at grant; later pat changes are ignored).
//         On tick: dwell<=dwell-1. On expiry (tick with dwell==1):
//           no req           -> IDLE, gnt<=0
//           winner == current -> stay in SHOW, re-latch pat, reload dwell
//           winner != current -> GAP, gnt<=0, q<=0
//         Preemption: if any req of strictly higher priority than current is asserted in SHOW,
//           grant it the next cycle, latch its pat, and reload dwell. Preemption bypasses GAP and
//           wins over a coincident expiry.
//   GAP:  q=0 for exactly one full tick period; on the next tick go to IDLE-arbitration
//         (a pending req is granted directly, same cycle). Preemption is not evaluated in GAP.
//  Dropping req during SHOW has no effect until expiry (stretching). A one-cycle req pulse is
//  shown for the full dwell.
//  busy = (state != IDLE), registered. gnt is always one-hot or zero.
//  Reset asserted mid-operation returns everything to reset values immediately; after release,
//  the prescaler restarts from 0.
//  Dwell counter width is clog2(DWELL+1), minimum 1; it never underflows.
// CONFIGURATION
//  LED_ARB_BLINK_EN defined: adds input blink [NREQ-1:0]. If the granted source's blink bit
//   (sampled at grant) is set, q alternates latched pattern / 4'b0000 on every tick.
//   The phase starts at "on" at each grant or re-grant. IDLE and GAP are unaffected.
//  Not defined: the blink port does not exist; q is the latched pattern for the whole of SHOW.
// TESTING  (bench sets MXPRE=2, tick every 4 clocks, DWELL=3)
//  1 Reset then idle_pat=4'b0100, req=0 -> q=4'b0100 one cycle after release; gnt=0, busy=0.
//  2 req[2]=1 for 1 clock, pat2=4'hA -> next edge gnt=4'b0100, q=4'hA; held 3 ticks, then IDLE.
//  3 req[3] shown with pat3=4'h5; raise req[1], pat1=4'h3 mid-dwell -> next edge gnt=4'b0010,
//    q=4'h3, dwell reloaded to 3.
//  4 req[2] held at expiry, req[3] also high -> SHOW reloads for source 2 (no GAP); drop req[2]
//    -> at expiry GAP (q=0, gnt=0) for 4 clocks, then gnt=4'b1000.
//  5 Preempting req coincident with tick and dwell==1 -> preemption wins; no GAP, no IDLE cycle.
//  6 Assert reset during SHOW -> q=0, gnt=0, busy=0 asynchronously; a blink run with the macro
//    defined toggles q A/0 every 4 clocks, starting "on".

Source files
------------

// File: rtl/led_display_arbiter.sv
// Priority arbiter sharing the 4 front-panel LEDs between NREQ requesters and the idle pattern,
// with a minimum dwell per grant. Optional macro LED_ARB_BLINK_EN adds per-source blinking.
module led_display_arbiter #(
  parameter int NREQ  = 4,
  parameter int MXPRE = 21,
  parameter int DWELL = 3
)(
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] pat,
  input  logic [3:0]        idle_pat,
`ifdef LED_ARB_BLINK_EN
  input  logic [NREQ-1:0]   blink,
`endif
  output logic [3:0]        q,
  output logic [NREQ-1:0]   gnt,
  output logic              busy
);

  localparam int DW  = (DWELL < 1) ? 1 : DWELL;
  localparam int DWW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t           state, state_n;
  logic [MXPRE-1:0] pre;
  logic [DWW-1:0]   dwell, dwell_n;
  logic [3:0]       lat, lat_n, q_n, win_pat;
  logic [NREQ-1:0]  gnt_n, win_oh;
  logic             tick, any_req, preempt, do_grant;
`ifdef LED_ARB_BLINK_EN
  logic             blk, blk_n, ph, ph_n;
`endif

  assign tick    = &pre;
  assign any_req = |req;
  // gnt - 1 masks every source with a strictly lower index (higher priority) than the holder
  assign preempt = (state == SHOW) && |(req & (gnt - NREQ'(1)));

  always_comb begin
    win_oh  = '0;
    win_pat = '0;
    for (int i = NREQ-1; i >= 0; i--)
      if (req[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_pat   = pat[4*i +: 4];
      end
  end

  always_comb begin
    state_n  = state;
    dwell_n  = dwell;
    lat_n    = lat;
    gnt_n    = gnt;
    q_n      = q;
    do_grant = 1'b0;
`ifdef LED_ARB_BLINK_EN
    blk_n    = blk;
    ph_n     = ph;
`endif
    case (state)
      IDLE: begin
        q_n      = idle_pat;
        do_grant = any_req;
      end
      SHOW: begin
        if (preempt) do_grant = 1'b1;
        else if (tick && dwell == DWW'(1)) begin
          if (!any_req) begin
            state_n = IDLE;
            gnt_n   = '0;
            q_n     = idle_pat;
          end else if (win_oh == gnt) do_grant = 1'b1;
          else begin
            state_n = GAP;
            gnt_n   = '0;
            q_n     = '0;
          end
        end else begin
          if (tick) dwell_n = dwell - DWW'(1);
`ifdef LED_ARB_BLINK_EN
          if (tick) ph_n = ph ^ blk;
          q_n = (blk && !ph_n) ? 4'b0000 : lat;
`else
          q_n = lat;
`endif
        end
      end
      GAP: begin
        q_n = '0;
        if (tick) begin
          if (any_req) do_grant = 1'b1;
          else begin
            state_n = IDLE;
            q_n     = idle_pat;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // grant, re-grant and preemption all restart the dwell from the current winner
    if (do_grant) begin
      state_n = SHOW;
      gnt_n   = win_oh;
      lat_n   = win_pat;
      q_n     = win_pat;
      dwell_n = DWW'(DW);
`ifdef LED_ARB_BLINK_EN
      blk_n   = |(blink & win_oh);
      ph_n    = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pre   <= '0;
      dwell <= '0;
      lat   <= '0;
      q     <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
`ifdef LED_ARB_BLINK_EN
      blk   <= 1'b0;
      ph    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      pre   <= pre + MXPRE'(1);
      dwell <= dwell_n;
      lat   <= lat_n;
      q     <= q_n;
      gnt   <= gnt_n;
      busy  <= (state_n != IDLE);
`ifdef LED_ARB_BLINK_EN
      blk   <= blk_n;
      ph    <= ph_n;
`endif
    end
  end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Randomized and directed checks of led_display_arbiter against a cycle-level behavioural model.
module tb_led_display_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] pat = '0;
  logic [3:0]  idle_pat = '0;
  logic [3:0]  q, gnt;
  logic        busy;
`ifdef LED_ARB_BLINK_EN
  logic [3:0]  blink = '0;
`endif

  led_display_arbiter #(.NREQ(4), .MXPRE(2), .DWELL(3)) dut (
    .clock(clock), .reset(reset), .req(req), .pat(pat), .idle_pat(idle_pat),
`ifdef LED_ARB_BLINK_EN
    .blink(blink),
`endif
    .q(q), .gnt(gnt), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 showing source m_cur, 2 blank gap; k counts edges since reset release
  int         m_mode, m_cur, m_left, k;
  logic [3:0] m_lat, e_q, e_gnt;
  logic       e_busy;

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_left = 0; k = 0; m_lat = 0;
    e_q = 0; e_gnt = 0; e_busy = 0;
  endtask

  task automatic grant(input int i);
    m_mode = 1; m_cur = i; m_left = 3; m_lat = pat[4*i +: 4]; e_q = m_lat;
  endtask

  task automatic model_step();
    int hi;
    bit tk;
    hi = -1;
    for (int i = 3; i >= 0; i--) if (req[i]) hi = i;
    tk = (k % 4) == 3;
    k++;
    case (m_mode)
      0: begin
        e_q = idle_pat;
        if (hi >= 0) grant(hi);
      end
      1: begin
        if (hi >= 0 && hi < m_cur) grant(hi);
        else if (tk && m_left == 1) begin
          if (hi < 0) begin m_mode = 0; e_q = idle_pat; end
          else if (hi == m_cur) grant(hi);
          else begin m_mode = 2; e_q = 0; end
        end else begin
          if (tk) m_left--;
          e_q = m_lat;
        end
      end
      default: begin
        e_q = 0;
        if (tk) begin
          if (hi >= 0) grant(hi);
          else begin m_mode = 0; e_q = idle_pat; end
        end
      end
    endcase
    e_gnt  = (m_mode == 1) ? 4'(1 << m_cur) : 4'b0000;
    e_busy = (m_mode != 0);
  endtask

  // called at a negedge: drive, predict, let one edge pass, compare at the next negedge
  task automatic cycle(input logic [3:0] r, input logic [15:0] p);
    req = r; pat = p;
    model_step();
    @(posedge clock);
    @(negedge clock);
    chk("q", 32'(q), 32'(e_q));
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_mode != 0 && n < 40) begin cycle(4'b0000, 16'h0); n++; end
    chk("reach_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    logic [3:0] r;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle_pat = 4'b0100;

    // idle pattern passes through
    cycle(4'b0000, 16'h0);
    chk("t1_q", 32'(q), 32'h4);

    // one-clock request stretched over the dwell
    cycle(4'b0100, 16'h0A00);
    chk("t2_gnt", 32'(gnt), 32'h4);
    chk("t2_q", 32'(q), 32'hA);
    wait_idle();

    // higher priority preempts mid-dwell
    cycle(4'b1000, 16'h5000);
    cycle(4'b1000, 16'h5000);
    cycle(4'b1010, 16'h5030);
    chk("t3_gnt", 32'(gnt), 32'h2);
    chk("t3_q", 32'(q), 32'h3);
    wait_idle();

    // held request reloads; dropping it leads through a one-tick gap
    repeat (14) cycle(4'b1100, 16'h5A00);
    chk("t4_hold", 32'(gnt), 32'h4);
    cnt = 0;
    while (gnt != 0 && cnt < 16) begin cycle(4'b1000, 16'h5000); cnt++; end
    chk("t4_gap_q", 32'(q), 32'h0);
    cnt = 1;
    while (gnt == 0 && cnt < 10) begin cycle(4'b1000, 16'h5000); if (gnt == 0) cnt++; end
    chk("t4_gap_len", 32'(cnt), 32'd4);
    chk("t4_next", 32'(gnt), 32'h8);

    // preemption coincident with expiry
    cnt = 0;
    while (!(m_mode == 1 && m_left == 1 && (k % 4) == 3) && cnt < 20) begin
      cycle(4'b0000, 16'h0); cnt++;
    end
    chk("t5_reach", 32'(m_mode == 1 && m_left == 1), 32'd1);
    cycle(4'b0001, 16'h000C);
    chk("t5_gnt", 32'(gnt), 32'h1);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_q", 32'(q), 32'hC);

    // randomized traffic
    r = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0)
        for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) idle_pat = 4'($urandom);
      cycle(r, 16'($urandom));
    end

    // asynchronous reset during SHOW
    cycle(4'b0001, 16'h0007);
    #2 reset = 1'b1;
    #1;
    chk("arst_q", 32'(q), 32'd0);
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    cycle(4'b0000, 16'h0);
    chk("post_rst_q", 32'(q), 32'(idle_pat));

`ifdef LED_ARB_BLINK_EN
    // blink: on for 3 clocks after grant, then alternating every tick
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    blink = 4'b0100; req = 4'b0100; pat = 16'h0A00;
    reset = 1'b0;
    for (int j = 0; j < 11; j++) begin
      @(posedge clock);
      @(negedge clock);
      req = 4'b0000;
      chk("blink_q", 32'(q), ((((j + 1) / 4) % 2) == 1) ? 32'h0 : 32'hA);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
